// File: rtl/logger_pkg.sv
// Shared constants, FSM encoding and nibble-to-ASCII helper for the logger line formatter.
package logger_pkg;

    // Rendered line: "SSSS TTTTTTTTTTTTTTTT\r\n"
    localparam int LOGGER_LINE_LEN = 23;
    localparam int IDX_SEP         = 4;
    localparam int IDX_CR          = 21;
    localparam int IDX_LF          = 22;

    // Free FIFO entries that must remain before a line may start; with this much
    // headroom a started line can never overrun the FIFO.
    localparam int LOGGER_HEADROOM = 56;

    // Default FIFO sizing; prog_full asserts once fewer than LOGGER_HEADROOM entries are free.
    localparam int LOGGER_FIFO_DEPTH       = 512;
    localparam int LOGGER_PROG_FULL_THRESH = LOGGER_FIFO_DEPTH - LOGGER_HEADROOM;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } fmt_state_t;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase)
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/logger_line_formatter.sv
// Renders one {seq, ts} record per handshake as a 23-byte ASCII line into the FIFO write port.
module logger_line_formatter
    import logger_pkg::*;
#(
    parameter bit DROP_WHEN_BUSY = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rec_valid,
    output logic        o_rec_ready,
    input  logic [15:0] i_rec_seq,
    input  logic [63:0] i_rec_ts,
    output logic        o_wr_en,
    output logic [7:0]  o_din,
    input  logic        i_full,
    input  logic        i_prog_full,
    output logic [15:0] o_drop_cnt
);

    fmt_state_t  r_state;
    fmt_state_t  w_state_nxt;
    logic [4:0]  r_idx;
    logic [4:0]  w_idx_nxt;
    logic [15:0] r_seq_q;
    logic [63:0] r_ts_q;
    logic [15:0] r_drop_cnt;

    logic        w_rec_ready;
    logic        w_wr_en;
    logic        w_accept;
    logic        w_drop;
    logic [1:0]  w_seq_pos;
    logic [3:0]  w_ts_pos;
    logic [7:0]  w_byte;

    // Next-state, byte index and handshake/write strobes; reset forces all strobes low.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rec_ready = 1'b0;
        w_wr_en     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_rec_ready = DROP_WHEN_BUSY ? 1'b1 : !i_prog_full;
                w_accept    = i_rec_valid && w_rec_ready && !i_prog_full && !i_rst;
                if (w_accept) begin
                    w_state_nxt = EMIT;
                    w_idx_nxt   = 5'd0;
                end
            end
            EMIT: begin
                // prog_full is deliberately ignored here: admission already guaranteed room.
                w_rec_ready = DROP_WHEN_BUSY;
                w_wr_en     = !i_full;
                if (w_wr_en) begin
                    if (r_idx == 5'(IDX_LF)) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = 5'd0;
                    end else begin
                        w_idx_nxt = r_idx + 5'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_rst) begin
            w_rec_ready = 1'b0;
            w_wr_en     = 1'b0;
        end
    end

    // In drop mode every handshake that does not start a line is discarded.
    assign w_drop = DROP_WHEN_BUSY && i_rec_valid && w_rec_ready && !w_accept;

    // Byte map: nibble position counts down from the MS nibble as idx advances.
    always_comb begin
        w_seq_pos = 2'd3 - r_idx[1:0];
        w_ts_pos  = 4'(5'd20 - r_idx);
        w_byte    = 8'h00;
        if (r_idx < 5'(IDX_SEP))
            w_byte = hex_ascii(r_seq_q[{w_seq_pos, 2'b00} +: 4]);
        else if (r_idx == 5'(IDX_SEP))
            w_byte = 8'h20;
        else if (r_idx < 5'(IDX_CR))
            w_byte = hex_ascii(r_ts_q[{w_ts_pos, 2'b00} +: 4]);
        else if (r_idx == 5'(IDX_CR))
            w_byte = 8'h0D;
        else
            w_byte = 8'h0A;
    end

    // FSM state and byte index register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Record latch on accept and saturating drop counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seq_q    <= 16'h0;
            r_ts_q     <= 64'h0;
            r_drop_cnt <= 16'h0;
        end else begin
            if (w_accept) begin
                r_seq_q <= i_rec_seq;
                r_ts_q  <= i_rec_ts;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_rec_ready = w_rec_ready;
    assign o_wr_en     = w_wr_en;
    assign o_din       = (r_state == EMIT && !i_rst) ? w_byte : 8'h00;
    assign o_drop_cnt  = r_drop_cnt;

endmodule
